approx_mul_acc: RTL
===================

Name: approx_mul_acc

Overview:
- Streaming accumulator sitting directly downstream of the 16x16 unsigned approximate multipliers.
- Consumes one 32-bit product per handshake and sums a programmable number of products into a frame result.
- Presents the frame result on a valid/ready output port.
- Used to evaluate dot-product and filter kernels built on approximate multipliers, and to measure their accumulated error on FPGA.

Parameters:
- PROD_W, 32, width of the incoming product (multiplier O output).
- ACC_W, 36, accumulator and result width. Must be >= PROD_W; elaboration-time error otherwise.
- LEN_W, 8, width of the frame-length field.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cfg_len  input  LEN_W  products per frame. Sampled only on the first beat of a frame; 0 is treated as 1.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_prod  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  frame sum.
- out_ovf  output  1  at least one carry out of ACC_W occurred during the frame.
- busy  output  1  a frame is in progress or a result is pending.

Behaviour:
- Beat acceptance: a beat transfers when in_valid && in_ready on a rising clk edge.
- Reset (rst_n low at a clock edge) forces:
  - state=IDLE, acc=0, cnt=0, len_q=0
  - in_ready=0 during reset, in_ready=1 on the first cycle after reset
  - out_valid=0, out_acc=0, out_ovf=0, busy=0
- Reset mid-frame or mid-HOLD discards all partial state; no result is emitted.
- State IDLE:
  - in_ready=1, busy=0.
  - On transfer: len_q = max(cfg_len,1), acc = zero-extended in_prod, cnt=1, ovf=0.
  - If len_q==1, go to HOLD; otherwise go to ACCUM.
- State ACCUM:
  - in_ready=1, busy=1.
  - On transfer: acc = acc + in_prod (ACC_W-bit add), ovf |= carry out, cnt++.
  - When the post-increment cnt == len_q, go to HOLD.
  - No transfer: all state holds.
  - Gaps of any length in in_valid are allowed.
- State HOLD:
  - in_ready=0, busy=1, out_valid=1.
  - out_acc = acc and out_ovf = ovf are registered and stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE: out_valid=0, acc cleared.
  - The next frame can start in the cycle after the result handshake.
- Latency: result valid one cycle after the last input beat is accepted. Throughput is N beats plus 1 handshake cycle per frame.
- Arithmetic:
  - Unsigned only; in_prod is zero-extended to ACC_W.
  - Overflow wraps modulo 2^ACC_W unless the optional feature is enabled.
- Changes to cfg_len during a frame are ignored.
- All outputs are driven from registers; there is no combinational path from in_* to out_*, or from out_ready to in_ready.
- cnt is LEN_W bits. len_q max is 2^LEN_W-1, so cnt never wraps.

Optional Feature:
- Macro: APPROX_MUL_ACC_SAT_EN.
- Defined: on carry out of ACC_W, acc saturates to all-ones and stays there for the rest of the frame. out_ovf still reports that saturation occurred.
- Undefined: the accumulator wraps modulo 2^ACC_W, and out_ovf reports any carry out.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while in_valid=1 -> out_valid=0, in_ready=0, busy=0, out_acc=0. in_ready=1 on the first cycle after release.
- Basic frame: cfg_len=4, products 0x0200_0000, 0x0400_0000, 0x0600_0000, 0x0800_0000 back-to-back -> out_valid one cycle after beat 4, out_acc=0x0_1400_0000, out_ovf=0.
- cfg_len=0 with a single beat 0xFE00_0000 -> treated as length 1, out_acc=0x0_FE00_0000 on the next cycle.
- Backpressure plus bubbles:
  - Stimulus: cfg_len=3, products 5, 7, 9 with in_valid gaps of 2 cycles; out_ready=0 for 5 cycles.
  - Required: out_acc=21 stable and in_ready=0 throughout the stall. Idle with in_ready=1 the cycle after out_ready=1.
- Overflow: cfg_len=32, every product 0xFFFF_FFFF -> sum 0x1F_FFFF_FFE0 exceeds 2^36-1.
  - Without APPROX_MUL_ACC_SAT_EN: out_acc=0xF_FFFF_FFE0, out_ovf=1.
  - With APPROX_MUL_ACC_SAT_EN: out_acc=0xF_FFFF_FFFF, out_ovf=1.
- Mid-frame reset: cfg_len=8, assert rst_n=0 after beat 3 -> no out_valid. The next frame cfg_len=2 with products 1, 2 gives out_acc=3.

Source files
------------

// File: rtl/approx_mul_acc.sv
// Streaming accumulator that sums a programmable number of multiplier products per frame.
// Optional feature: define APPROX_MUL_ACC_SAT_EN to saturate on carry out instead of wrapping.
module approx_mul_acc #(
  parameter int unsigned PROD_W = 32,
  parameter int unsigned ACC_W  = 36,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  if (ACC_W < PROD_W) begin : g_bad_width
    $error("approx_mul_acc: ACC_W must be >= PROD_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum;
  logic               accept;

  assign prod_ext = ACC_W'(in_prod);
  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};
  assign accept   = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          len_d   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
          acc_d   = prod_ext;
          cnt_d   = LEN_W'(1);
          ovf_d   = 1'b0;
          state_d = (len_d == LEN_W'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
`ifdef APPROX_MUL_ACC_SAT_EN
          // Once saturated, every further add carries again, so acc stays all-ones.
          acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d = ovf_q | sum[ACC_W];
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: low through reset, high from the first cycle after it.
    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == HOLD);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule
